rf_writeback: RTL and testbench

Write-side front end for the integer register file. Merges results from the single-cycle ALU and the variable-latency load unit onto the single register-file write port (we3/a3/wd3). Load data is byte/half/word extracted and extended before it is buffered, and writes to x0 are suppressed. A pending-load scoreboard bitmap is exported to the hazard logic.

---
 rtl/rf_writeback.sv | 136 +++++++++++++
 tb/tb_rf_writeback.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback.sv
// Register-file write port front end: merges ALU results with buffered, extended
// load results, suppresses x0 writes and tracks outstanding loads per register.
module rf_writeback #(
    parameter  int XLen      = 32,
    parameter  int NReg      = 32,
    parameter  int FifoDepth = 2,
    localparam int NRegWidth = $clog2(NReg)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 alu_valid_i,
    input  logic [NRegWidth-1:0] alu_rd_i,
    input  logic [XLen-1:0]      alu_data_i,
    input  logic                 ld_issue_i,
    input  logic [NRegWidth-1:0] ld_issue_rd_i,
    input  logic                 ld_valid_i,
    output logic                 ld_ready_o,
    input  logic [NRegWidth-1:0] ld_rd_i,
    input  logic [XLen-1:0]      ld_data_i,
    input  logic [2:0]           ld_funct3_i,
    input  logic [1:0]           ld_offset_i,
    output logic                 we3_o,
    output logic [NRegWidth-1:0] a3_o,
    output logic [XLen-1:0]      wd3_o,
    output logic [NReg-1:0]      pending_o
);
    localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CntW = $clog2(FifoDepth + 1);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(FifoDepth - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(FifoDepth);

    logic [XLen-1:0]      data_mem [FifoDepth];
    logic [NRegWidth-1:0] rd_mem   [FifoDepth];
    logic [PtrW-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [CntW-1:0]      count_reg;
    logic                 we3_reg;
    logic [NRegWidth-1:0] a3_reg;
    logic [XLen-1:0]      wd3_reg;
    logic [NReg-1:0]      pending_reg, pending_next;

    logic                 push, pop, fifo_nonempty, sel_valid;
    logic [NRegWidth-1:0] head_rd, sel_rd;
    logic [XLen-1:0]      sel_data, ext_data;

    function automatic logic [XLen-1:0] load_ext(input logic [XLen-1:0] word,
                                                 input logic [2:0] funct3,
                                                 input logic [1:0] off);
        logic [7:0]  byte_val;
        logic [15:0] half_val;
        byte_val = word[{off, 3'b000} +: 8];
        half_val = word[{off[1], 4'b0000} +: 16];
        case (funct3)
            3'b000:  return {{(XLen-8){byte_val[7]}}, byte_val};
            3'b001:  return {{(XLen-16){half_val[15]}}, half_val};
            3'b100:  return {{(XLen-8){1'b0}}, byte_val};
            3'b101:  return {{(XLen-16){1'b0}}, half_val};
            default: return word;
        endcase
    endfunction

    // Ready comes only from the registered count, so a full buffer refuses a
    // push even in the cycle it is being popped.
    assign ld_ready_o    = (count_reg < DepthCnt);
    assign fifo_nonempty = (count_reg != '0);
    assign push          = ld_valid_i && ld_ready_o;
    assign pop           = !alu_valid_i && fifo_nonempty;
    assign ext_data      = load_ext(ld_data_i, ld_funct3_i, ld_offset_i);
    assign head_rd       = rd_mem[rd_ptr_reg];

    assign sel_valid = alu_valid_i || fifo_nonempty;
    assign sel_rd    = alu_valid_i ? alu_rd_i : head_rd;
    assign sel_data  = alu_valid_i ? alu_data_i : data_mem[rd_ptr_reg];

    always_ff @(posedge clk_i) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= ext_data;
            rd_mem[wr_ptr_reg]   <= ld_rd_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= (wr_ptr_reg == LastPtr) ? '0 : wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= (rd_ptr_reg == LastPtr) ? '0 : rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Address and data follow the selected source even for x0, and hold otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we3_reg <= 1'b0;
            a3_reg  <= '0;
            wd3_reg <= '0;
        end else begin
            we3_reg <= sel_valid && (sel_rd != '0);
            if (sel_valid) begin
                a3_reg  <= sel_rd;
                wd3_reg <= sel_data;
            end
        end
    end

    // A new issue to the same register overrides the retiring load's clear.
    genvar gi;
    generate
        for (gi = 0; gi < NReg; gi++) begin : g_pending
            if (gi == 0) begin : g_x0
                assign pending_next[gi] = 1'b0;
            end else begin : g_xr
                logic set_bit, clr_bit;
                assign set_bit = ld_issue_i && (ld_issue_rd_i == NRegWidth'(gi));
                assign clr_bit = pop && (head_rd == NRegWidth'(gi));
                assign pending_next[gi] = set_bit || (pending_reg[gi] && !clr_bit);
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pending_reg <= '0;
        else         pending_reg <= pending_next;
    end

    assign we3_o     = we3_reg;
    assign a3_o      = a3_reg;
    assign wd3_o     = wd3_reg;
    assign pending_o = pending_reg;
endmodule

// File: tb/tb_rf_writeback.sv
// Directed and random stimulus for rf_writeback, checked against a queue-based
// reference model of the write-port merge, load extension and pending bitmap.
module tb_rf_writeback;
    localparam int Depth = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        alu_valid_i, ld_issue_i, ld_valid_i, ld_ready_o, we3_o;
    logic [4:0]  alu_rd_i, ld_issue_rd_i, ld_rd_i, a3_o;
    logic [31:0] alu_data_i, ld_data_i, wd3_o, pending_o;
    logic [2:0]  ld_funct3_i;
    logic [1:0]  ld_offset_i;

    rf_writeback #(.XLen(32), .NReg(32), .FifoDepth(Depth)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
        .ld_issue_i(ld_issue_i), .ld_issue_rd_i(ld_issue_rd_i),
        .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_rd_i(ld_rd_i),
        .ld_data_i(ld_data_i), .ld_funct3_i(ld_funct3_i), .ld_offset_i(ld_offset_i),
        .we3_o(we3_o), .a3_o(a3_o), .wd3_o(wd3_o), .pending_o(pending_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic        m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd3, m_pend;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] ref_ext(logic [31:0] w, logic [2:0] f3, logic [1:0] off);
        int unsigned b, h;
        b = (w >> (8 * int'(off))) & 32'hFF;
        h = (w >> (16 * int'(off[1]))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_we = 1'b0; m_a3 = '0; m_wd3 = '0; m_pend = '0;
    endtask

    task automatic check_all(string tag);
        chk({tag, ".we3"}, {31'b0, we3_o}, {31'b0, m_we});
        chk({tag, ".a3"}, {27'b0, a3_o}, {27'b0, m_a3});
        chk({tag, ".wd3"}, wd3_o, m_wd3);
        chk({tag, ".pending"}, pending_o, m_pend);
        chk({tag, ".ready"}, {31'b0, ld_ready_o}, {31'b0, q.size() < Depth});
    endtask

    // Advance the model by one edge using the inputs currently applied.
    task automatic step(string tag);
        ent_t e;
        bit   ready;
        ready = q.size() < Depth;
        if (alu_valid_i) begin
            m_we = (alu_rd_i != 0); m_a3 = alu_rd_i; m_wd3 = alu_data_i;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            m_we = (e.rd != 0); m_a3 = e.rd; m_wd3 = e.data;
            m_pend[e.rd] = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        if (ld_issue_i && ld_issue_rd_i != 0) m_pend[ld_issue_rd_i] = 1'b1;
        if (ld_valid_i && ready) begin
            e.rd = ld_rd_i; e.data = ref_ext(ld_data_i, ld_funct3_i, ld_offset_i);
            q.push_back(e);
        end
        @(posedge clk_i);
        #1;
        check_all(tag);
        $display("%s: we3=%0b a3=%0d wd3=%h pending=%h ready=%0b", tag, we3_o, a3_o, wd3_o, pending_o, ld_ready_o);
    endtask

    task automatic idle_inputs();
        alu_valid_i = 0; alu_rd_i = 0; alu_data_i = 0;
        ld_issue_i = 0; ld_issue_rd_i = 0;
        ld_valid_i = 0; ld_rd_i = 0; ld_data_i = 0; ld_funct3_i = 0; ld_offset_i = 0;
    endtask

    logic [2:0]  ext_f3  [6] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b011};
    logic [1:0]  ext_off [6] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd0, 2'd0};
    logic [31:0] ext_exp [6] = '{32'h0000007F, 32'hFFFFFFF2, 32'h00000080,
                                 32'hFFFF8081, 32'h0000F27F, 32'h8081F27F};

    initial begin
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_all("reset");
        rst_ni = 1'b1;
        step("idle");

        // ALU write lands one cycle later, then the port goes idle.
        alu_valid_i = 1; alu_rd_i = 5; alu_data_i = 32'hDEADBEEF;
        step("alu");
        chk("alu.a3_const", {27'b0, a3_o}, 32'd5);
        chk("alu.wd3_const", wd3_o, 32'hDEADBEEF);
        idle_inputs();
        step("alu.after");

        for (int i = 0; i < 6; i++) begin
            ld_valid_i = 1; ld_rd_i = 3; ld_data_i = 32'h8081F27F;
            ld_funct3_i = ext_f3[i]; ld_offset_i = ext_off[i];
            step("ext.push");
            idle_inputs();
            step("ext.write");
            chk("ext.const", wd3_o, ext_exp[i]);
        end

        // Loads stall behind ALU traffic; a third load is refused while full.
        alu_valid_i = 1; alu_rd_i = 1; alu_data_i = 32'h11;
        ld_valid_i = 1; ld_rd_i = 7; ld_data_i = 32'h77;  ld_funct3_i = 3'b010;
        step("conf.0");
        ld_rd_i = 8; ld_data_i = 32'h88;
        step("conf.1");
        chk("conf.full", {31'b0, ld_ready_o}, 32'd0);
        ld_rd_i = 10; ld_data_i = 32'hAA;
        step("conf.2");
        step("conf.3");
        alu_valid_i = 0;
        step("conf.pop7");
        chk("conf.rd7", {27'b0, a3_o}, 32'd7);
        step("conf.pop8");
        ld_valid_i = 0;
        step("conf.pop10");
        step("conf.drain");

        // x0 targets from both sources never assert we3.
        idle_inputs();
        alu_valid_i = 1; alu_rd_i = 0; alu_data_i = 32'h1234;
        step("x0.alu");
        chk("x0.alu_we", {31'b0, we3_o}, 32'd0);
        idle_inputs();
        ld_valid_i = 1; ld_rd_i = 0; ld_data_i = 32'h5555; ld_funct3_i = 3'b010;
        ld_issue_i = 1; ld_issue_rd_i = 0;
        step("x0.ld");
        idle_inputs();
        step("x0.pop");
        chk("x0.ld_we", {31'b0, we3_o}, 32'd0);
        chk("x0.pend0", {31'b0, pending_o[0]}, 32'd0);

        // Scoreboard set, clear, and same-edge reissue.
        ld_issue_i = 1; ld_issue_rd_i = 9;
        step("sb.issue9");
        chk("sb.set9", {31'b0, pending_o[9]}, 32'd1);
        idle_inputs();
        ld_issue_i = 1; ld_issue_rd_i = 11;
        ld_valid_i = 1; ld_rd_i = 11; ld_data_i = 32'hB; ld_funct3_i = 3'b010;
        step("sb.resp11");
        idle_inputs();
        step("sb.wr11");
        chk("sb.clr11", {31'b0, pending_o[11]}, 32'd0);
        ld_valid_i = 1; ld_rd_i = 9; ld_data_i = 32'h9; ld_funct3_i = 3'b010;
        step("sb.resp9");
        idle_inputs();
        ld_issue_i = 1; ld_issue_rd_i = 9;
        step("sb.reissue9");
        chk("sb.hold9", {31'b0, pending_o[9]}, 32'd1);
        chk("sb.we9", {31'b0, we3_o}, 32'd1);
        idle_inputs();

        for (int i = 0; i < 400; i++) begin
            alu_valid_i   = ($urandom_range(0, 99) < 40);
            alu_rd_i      = 5'($urandom);
            alu_data_i    = $urandom;
            ld_issue_i    = ($urandom_range(0, 99) < 30);
            ld_issue_rd_i = 5'($urandom);
            ld_valid_i    = ($urandom_range(0, 99) < 50);
            ld_rd_i       = 5'($urandom);
            ld_data_i     = $urandom;
            ld_funct3_i   = 3'($urandom);
            ld_offset_i   = 2'($urandom);
            step("rand");
        end

        // Asynchronous reset with two buffered loads and pending bits.
        idle_inputs();
        alu_valid_i = 1; alu_rd_i = 2; alu_data_i = 32'h22;
        ld_issue_i = 1; ld_issue_rd_i = 13;
        ld_valid_i = 1; ld_rd_i = 13; ld_data_i = 32'hD; ld_funct3_i = 3'b010;
        step("rst.fill0");
        ld_issue_rd_i = 14; ld_rd_i = 14;
        step("rst.fill1");
        #2 rst_ni = 1'b0;
        #1;
        model_reset();
        check_all("rst.async");
        idle_inputs();
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) step("rst.after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
